tart_block_sequencer: RTL and testbench

TART_BLOCK_SEQUENCER -- requirements
Module: tart_block_sequencer

---
 rtl/tart_block_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_tart_block_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tart_block_sequencer.sv
// Block sequencer for a time-multiplexed correlator.
// Generates the correlator enable, the accumulator clear (sw_o) and the
// read/write addresses. It also counts samples into blocks and rotates the
// visibility banks with a small pending-readback ledger.
//
// Ports:
//   clk_x        correlator clock; this is the only clock domain
//   rst_ni       asynchronous active-low reset
//   enable_i     acquisition enable, already synchronous to clk_x
//   blocksize_i  samples per block minus 1; latched at run start and at each bank switch
//   streamed_i   pulse: the oldest pending bank has been fully read back
//   en_o         correlator enable, high while running
//   sw_o         accumulator clear/overwrite during the first sample of a block
//   rd_adr_o     accumulator read address (the tmux counter)
//   wr_adr_o     accumulator write address (rd_adr_o delayed by PIPE cycles)
//   bank_o       bank currently being written
//   rd_bank_o    oldest pending bank for readback
//   pending_o    number of completed banks that have not been read back
//   newblock_o   one-cycle pulse after each committed bank switch
//   overflow_o   sticky flag: a block was discarded because all banks were full
module tart_block_sequencer #(
    parameter int unsigned TRATE = 12,
    parameter int unsigned TBITS = 4,
    parameter int unsigned BLOCK = 24,
    parameter int unsigned XBITS = 4,
    parameter int unsigned PIPE  = 2
) (
    input  logic             clk_x,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [BLOCK-1:0] blocksize_i,
    input  logic             streamed_i,
    output logic             en_o,
    output logic             sw_o,
    output logic [TBITS-1:0] rd_adr_o,
    output logic [TBITS-1:0] wr_adr_o,
    output logic [XBITS-1:0] bank_o,
    output logic [XBITS-1:0] rd_bank_o,
    output logic [XBITS-1:0] pending_o,
    output logic             newblock_o,
    output logic             overflow_o
);

    localparam logic [TBITS-1:0] TMUX_LAST = TBITS'(TRATE - 1);
    localparam logic [XBITS-1:0] PEND_MAX  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [TBITS-1:0] tmux_q, tmux_d;
    logic [BLOCK-1:0] sample_q, sample_d;
    logic [BLOCK-1:0] blk_q, blk_d;
    logic [XBITS-1:0] bank_q, bank_d;
    logic [XBITS-1:0] rd_bank_q, rd_bank_d;
    logic [XBITS-1:0] pending_q, pending_d;
    logic             sw_q, sw_d;
    logic             newblock_q, newblock_d;
    logic             overflow_q, overflow_d;

    logic wrap;
    logic bank_switch;
    logic full;
    logic consume;
    logic commit;

    // State and counter registers.
    always_ff @(posedge clk_x or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            tmux_q     <= '0;
            sample_q   <= '0;
            blk_q      <= '0;
            bank_q     <= '0;
            rd_bank_q  <= '0;
            pending_q  <= '0;
            sw_q       <= 1'b0;
            newblock_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmux_q     <= tmux_d;
            sample_q   <= sample_d;
            blk_q      <= blk_d;
            bank_q     <= bank_d;
            rd_bank_q  <= rd_bank_d;
            pending_q  <= pending_d;
            sw_q       <= sw_d;
            newblock_q <= newblock_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic: sequencing, bank rotation and the readback ledger.
    always_comb begin
        state_d    = state_q;
        tmux_d     = tmux_q;
        sample_d   = sample_q;
        blk_d      = blk_q;
        bank_d     = bank_q;
        rd_bank_d  = rd_bank_q;
        pending_d  = pending_q;
        newblock_d = 1'b0;
        overflow_d = overflow_q;

        wrap        = (state_q == RUN) && (tmux_q == TMUX_LAST);
        bank_switch = wrap && (sample_q == blk_q);
        // A readback in the same cycle frees a slot, so the ledger is not full.
        full        = (pending_q == PEND_MAX) && !streamed_i;
        consume     = streamed_i && (pending_q != '0);
        commit      = bank_switch && !full;

        case (state_q)
            IDLE: begin
                tmux_d = '0;
                if (enable_i) begin
                    state_d = RUN;
                    blk_d   = blocksize_i;
                end
            end
            RUN: begin
                if (wrap) begin
                    tmux_d = '0;
                    if (bank_switch) begin
                        sample_d = '0;
                        blk_d    = blocksize_i;
                    end else begin
                        sample_d = sample_q + BLOCK'(1);
                    end
                    // Stop only on a sample boundary.
                    if (!enable_i) begin
                        state_d = IDLE;
                    end
                end else begin
                    tmux_d = tmux_q + TBITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // When all banks are full the current bank is rewritten; sw_o clears it again.
        if (commit) begin
            bank_d     = bank_q + XBITS'(1);
            newblock_d = 1'b1;
        end
        if (bank_switch && full) begin
            overflow_d = 1'b1;
        end

        if (consume) begin
            rd_bank_d = rd_bank_q + XBITS'(1);
        end
        if (commit && !consume) begin
            pending_d = pending_q + XBITS'(1);
        end else if (!commit && consume) begin
            pending_d = pending_q - XBITS'(1);
        end

        sw_d = (state_d == RUN) && (sample_d == '0);
    end

    // Write-address delay line; it holds while the sequencer is idle.
    generate
        if (PIPE == 0) begin : g_nopipe
            assign wr_adr_o = tmux_q;
        end else begin : g_pipe
            logic [TBITS-1:0] pipe_q [PIPE];

            always_ff @(posedge clk_x or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < PIPE; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else if (state_q == RUN) begin
                    pipe_q[0] <= tmux_q;
                    for (int i = 1; i < PIPE; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign wr_adr_o = pipe_q[PIPE-1];
        end
    endgenerate

    assign en_o       = (state_q == RUN);
    assign sw_o       = sw_q;
    assign rd_adr_o   = tmux_q;
    assign bank_o     = bank_q;
    assign rd_bank_o  = rd_bank_q;
    assign pending_o  = pending_q;
    assign newblock_o = newblock_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_tart_block_sequencer.sv
// Testbench for tart_block_sequencer.
// A reference model tracks position within the block, a FIFO of completed
// banks and an address history. The bench compares every DUT output with
// the model on each cycle.
module tb_tart_block_sequencer;

    localparam int TRATE = 12;
    localparam int TBITS = 4;
    localparam int BLOCK = 24;
    localparam int XBITS = 2;
    localparam int PIPE  = 2;
    localparam int NBANK = 1 << XBITS;

    logic             clk_x = 1'b0;
    logic             rst_ni;
    logic             enable_i;
    logic [BLOCK-1:0] blocksize_i;
    logic             streamed_i;
    logic             en_o;
    logic             sw_o;
    logic [TBITS-1:0] rd_adr_o;
    logic [TBITS-1:0] wr_adr_o;
    logic [XBITS-1:0] bank_o;
    logic [XBITS-1:0] rd_bank_o;
    logic [XBITS-1:0] pending_o;
    logic             newblock_o;
    logic             overflow_o;

    always #5 clk_x = ~clk_x;

    tart_block_sequencer #(
        .TRATE(TRATE),
        .TBITS(TBITS),
        .BLOCK(BLOCK),
        .XBITS(XBITS),
        .PIPE (PIPE)
    ) dut (
        .clk_x      (clk_x),
        .rst_ni     (rst_ni),
        .enable_i   (enable_i),
        .blocksize_i(blocksize_i),
        .streamed_i (streamed_i),
        .en_o       (en_o),
        .sw_o       (sw_o),
        .rd_adr_o   (rd_adr_o),
        .wr_adr_o   (wr_adr_o),
        .bank_o     (bank_o),
        .rd_bank_o  (rd_bank_o),
        .pending_o  (pending_o),
        .newblock_o (newblock_o),
        .overflow_o (overflow_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_run;
    int m_pos;      // run cycles elapsed inside the current block
    int m_blk;      // latched samples-per-block minus 1
    int m_bank;
    bit m_nb;
    bit m_ovf;
    int done_q[$];  // completed, unread banks (oldest first)
    int rdh[$];     // last PIPE read addresses issued while running

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_pos  = 0;
        m_blk  = 0;
        m_bank = 0;
        m_nb   = 1'b0;
        m_ovf  = 1'b0;
        done_q.delete();
        rdh.delete();
        for (int i = 0; i < PIPE; i++) rdh.push_back(0);
    endtask

    // Advances the model by one clock edge, using the current inputs.
    task automatic model_step();
        int blen;
        bit sw_ev;
        bit wrap;
        bit full;
        blen  = (m_blk + 1) * TRATE;
        sw_ev = m_run && (m_pos == blen - 1);
        wrap  = m_run && ((m_pos % TRATE) == TRATE - 1);
        full  = (done_q.size() == NBANK - 1) && !streamed_i;
        m_nb  = sw_ev && !full;
        if (sw_ev && full) m_ovf = 1'b1;
        if (m_run) begin
            rdh.push_back(m_pos % TRATE);
            void'(rdh.pop_front());
        end
        if (streamed_i && done_q.size() > 0) void'(done_q.pop_front());
        if (m_nb) begin
            done_q.push_back(m_bank);
            m_bank = (m_bank + 1) % NBANK;
        end
        if (m_run) begin
            if (sw_ev) begin
                m_pos = 0;
                m_blk = int'(blocksize_i);
            end else begin
                m_pos++;
            end
            if (wrap && !enable_i) m_run = 1'b0;
        end else if (enable_i) begin
            m_run = 1'b1;
            m_blk = int'(blocksize_i);
        end
    endtask

    task automatic check_outputs();
        chk("en", 32'(en_o), 32'(m_run));
        chk("sw", 32'(sw_o), 32'(m_run && (m_pos < TRATE)));
        chk("rd_adr", 32'(rd_adr_o), m_pos % TRATE);
        chk("wr_adr", 32'(wr_adr_o), rdh[0]);
        chk("bank", 32'(bank_o), m_bank);
        chk("rd_bank", 32'(rd_bank_o), (done_q.size() > 0) ? done_q[0] : m_bank);
        chk("pending", 32'(pending_o), done_q.size());
        chk("newblock", 32'(newblock_o), 32'(m_nb));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk_x);
        if (rst_ni) model_step();
        #1;
        check_outputs();
    endtask

    function automatic bit switch_next();
        return m_run && (m_pos == (m_blk + 1) * TRATE - 1);
    endfunction

    initial begin
        bit found;

        // Reset state
        rst_ni      = 1'b0;
        enable_i    = 1'b0;
        blocksize_i = BLOCK'(3);
        streamed_i  = 1'b0;
        model_reset();
        #12;
        check_outputs();

        // Continuous run, blocksize 3, no readback: pending fills, then overflow
        rst_ni   = 1'b1;
        enable_i = 1'b1;
        repeat (200) tick();
        chk("ovf_after_fill", 32'(overflow_o), 32'd1);
        chk("bank_held_at_3", 32'(bank_o), 32'd3);
        chk("pending_full", 32'(pending_o), 32'd3);
        for (int i = 0; i < 4; i++) begin
            streamed_i = 1'b1;
            tick();
            streamed_i = 1'b0;
            repeat (3) tick();
        end

        // Reset, then readback on the exact switch cycle while the ledger is full
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) tick();
        rst_ni      = 1'b1;
        blocksize_i = BLOCK'(0);
        found       = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (switch_next() && done_q.size() == NBANK - 1) begin
                streamed_i = 1'b1;
                tick();
                streamed_i = 1'b0;
                chk("coinc_pending", 32'(pending_o), 32'd3);
                chk("coinc_no_ovf", 32'(overflow_o), 32'd0);
                chk("coinc_bank", 32'(bank_o), 32'd0);
                chk("coinc_rd_bank", 32'(rd_bank_o), 32'd1);
                found = 1'b1;
            end else begin
                tick();
            end
        end
        chk("coinc_reached", 32'(found), 32'd1);

        // Drop enable at tmux=5 mid-block, then resume
        blocksize_i = BLOCK'(5);
        for (int i = 0; i < 4; i++) begin
            streamed_i = 1'b1;
            tick();
            streamed_i = 1'b0;
        end
        repeat (20) tick();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_run && (m_pos % TRATE) == 5 && m_pos >= TRATE) found = 1'b1;
            else tick();
        end
        chk("tmux5_reached", 32'(found), 32'd1);
        enable_i = 1'b0;
        repeat (6) tick();
        chk("en_held_to_wrap", 32'(en_o), 32'd1);
        chk("rd_adr_11", 32'(rd_adr_o), 32'd11);
        tick();
        chk("en_low_after_wrap", 32'(en_o), 32'd0);
        repeat (15) tick();
        enable_i = 1'b1;
        repeat (40) tick();

        // Asynchronous reset at sample 2 of a block
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (m_run && (m_pos / TRATE) == 2) found = 1'b1;
            else tick();
        end
        chk("sample2_reached", 32'(found), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_en", 32'(en_o), 32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
        #2;
        rst_ni = 1'b1;
        tick();
        chk("post_rst_sw", 32'(sw_o), 32'd1);
        chk("post_rst_bank", 32'(bank_o), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            enable_i    = ($urandom_range(0, 19) != 0);
            blocksize_i = BLOCK'($urandom_range(0, 3));
            streamed_i  = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
